// File: rtl/branch_predictor.sv
// Combined BHT/BTB branch predictor: direct-mapped table of
// {valid, tag, target, 2-bit saturating counter}, combinational lookup on
// the IF PC, training and misprediction detection from EX resolution.
module branch_predictor #(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = $clog2(ENTRIES),
   parameter int CNT_W   = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [31:0]      if_pc,
   output logic             pred_taken,
   output logic [31:0]      pred_target,
   output logic [31:0]      pred_pc_next,
   input  logic             ex_valid,
   input  logic [31:0]      ex_pc,
   input  logic             ex_taken,
   input  logic [31:0]      ex_target,
   input  logic             ex_pred_taken,
   input  logic [31:0]      ex_pred_target,
   output logic             mispredict,
   output logic [31:0]      redirect_pc,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] mispredict_count
);

   localparam int TAG_W = 30 - IDX_W;

   logic             valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [31:0]      target_q [ENTRIES];
   logic [1:0]       cnt_q    [ENTRIES];

   logic [IDX_W-1:0] if_idx;
   logic [TAG_W-1:0] if_tag;
   logic             if_hit;
   logic [IDX_W-1:0] ex_idx;
   logic [TAG_W-1:0] ex_tag;
   logic             ex_hit;
   logic             unused_ok;

   // The byte offset within a word never participates in indexing or tags.
   assign unused_ok = ^{if_pc[1:0], ex_pc[1:0]};

   // Lookup: reads the registered table only, so a same-cycle update is not bypassed.
   always_comb begin
      if_idx       = if_pc[IDX_W+1:2];
      if_tag       = if_pc[31:IDX_W+2];
      if_hit       = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
      pred_taken   = if_hit && cnt_q[if_idx][1];
      pred_target  = if_hit ? target_q[if_idx] : 32'd0;
      pred_pc_next = pred_taken ? pred_target : (if_pc + 32'd4);
   end

   // Resolution side: hit detection for training and the flush request.
   always_comb begin
      ex_idx      = ex_pc[IDX_W+1:2];
      ex_tag      = ex_pc[31:IDX_W+2];
      ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
      mispredict  = ex_valid && ((ex_taken != ex_pred_taken) ||
                                 (ex_taken && (ex_target != ex_pred_target)));
      redirect_pc = 32'd0;
      if (mispredict)
         redirect_pc = ex_taken ? ex_target : (ex_pc + 32'd4);
   end

   // Table training: strengthen/weaken on a hit, allocate or replace on a miss.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= 32'd0;
            cnt_q[i]    <= 2'b01;
         end
      end else if (ex_valid) begin
         if (ex_hit) begin
            if (ex_taken) begin
               target_q[ex_idx] <= ex_target;
               if (cnt_q[ex_idx] != 2'b11)
                  cnt_q[ex_idx] <= cnt_q[ex_idx] + 2'd1;
            end else if (cnt_q[ex_idx] != 2'b00) begin
               cnt_q[ex_idx] <= cnt_q[ex_idx] - 2'd1;
            end
         end else begin
            valid_q[ex_idx]  <= 1'b1;
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= ex_target;
            cnt_q[ex_idx]    <= ex_taken ? 2'b10 : 2'b01;
         end
      end
   end

   // Saturating statistics counters.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else begin
         if (ex_valid && (branch_count != '1))
            branch_count <= branch_count + 1'b1;
         if (mispredict && (mispredict_count != '1))
            mispredict_count <= mispredict_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: vector table for training/lookup
// sequences plus hand-written reset and counter-saturation sequences.
module tb_branch_predictor;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [31:0] if_pc = 32'h100;
   logic        ex_valid = 1'b0;
   logic [31:0] ex_pc = '0;
   logic        ex_taken = 1'b0;
   logic [31:0] ex_target = '0;
   logic        ex_pred_taken = 1'b0;
   logic [31:0] ex_pred_target = '0;

   logic        pred_taken, mispredict;
   logic [31:0] pred_target, pred_pc_next, redirect_pc;
   logic [15:0] branch_count, mispredict_count;

   logic        s_pred_taken, s_mispredict;
   logic [31:0] s_pred_target, s_pred_pc_next, s_redirect_pc;
   logic [2:0]  s_branch_count, s_mispredict_count;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   branch_predictor #(.ENTRIES(16), .CNT_W(16)) dut (
      .CLK(CLK), .RST(RST), .if_pc(if_pc),
      .pred_taken(pred_taken), .pred_target(pred_target), .pred_pc_next(pred_pc_next),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
      .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
      .mispredict(mispredict), .redirect_pc(redirect_pc),
      .branch_count(branch_count), .mispredict_count(mispredict_count)
   );

   // Narrow statistics counters so saturation is reachable in a few cycles.
   branch_predictor #(.ENTRIES(16), .CNT_W(3)) dut_s (
      .CLK(CLK), .RST(RST), .if_pc(if_pc),
      .pred_taken(s_pred_taken), .pred_target(s_pred_target), .pred_pc_next(s_pred_pc_next),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
      .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
      .mispredict(s_mispredict), .redirect_pc(s_redirect_pc),
      .branch_count(s_branch_count), .mispredict_count(s_mispredict_count)
   );

   typedef struct {
      logic        exv;
      logic [31:0] expc;
      logic        ext;
      logic [31:0] extgt;
      logic        expt;
      logic [31:0] exptgt;
      logic [31:0] ifpc;
      logic        e_pt;
      logic [31:0] e_ptgt;
      logic [31:0] e_pcn;
      logic        e_mis;
      logic [31:0] e_red;
      logic [15:0] e_bc;
      logic [15:0] e_mc;
   } vec_t;

   vec_t vecs[18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive_ex(input logic v, input logic [31:0] pc, input logic t,
                           input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
      ex_valid       = v;
      ex_pc          = pc;
      ex_taken       = t;
      ex_target      = tgt;
      ex_pred_taken  = pt;
      ex_pred_target = ptgt;
   endtask

   initial begin
      //            exv ex_pc     t  ex_tgt    pt ex_ptgt   if_pc         pt  ptgt      pc_next       mis red      bc  mc
      vecs[0]  = '{1'b1, 32'h40,  1'b1, 32'h10,  1'b0, 32'h0,  32'h100,     1'b0, 32'h0,   32'h104,     1'b1, 32'h10,  16'd0,  16'd0};
      vecs[1]  = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,  32'h40,      1'b1, 32'h10,  32'h10,      1'b0, 32'h0,   16'd1,  16'd1};
      vecs[2]  = '{1'b1, 32'h40,  1'b1, 32'h10,  1'b1, 32'h10, 32'h40,      1'b1, 32'h10,  32'h10,      1'b0, 32'h0,   16'd1,  16'd1};
      vecs[3]  = '{1'b1, 32'h40,  1'b1, 32'h10,  1'b1, 32'h10, 32'h40,      1'b1, 32'h10,  32'h10,      1'b0, 32'h0,   16'd2,  16'd1};
      vecs[4]  = '{1'b1, 32'h40,  1'b0, 32'h0,   1'b1, 32'h10, 32'h40,      1'b1, 32'h10,  32'h10,      1'b1, 32'h44,  16'd3,  16'd1};
      vecs[5]  = '{1'b1, 32'h40,  1'b0, 32'h0,   1'b1, 32'h10, 32'h40,      1'b1, 32'h10,  32'h10,      1'b1, 32'h44,  16'd4,  16'd2};
      vecs[6]  = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,  32'h40,      1'b0, 32'h10,  32'h44,      1'b0, 32'h0,   16'd5,  16'd3};
      vecs[7]  = '{1'b1, 32'h40,  1'b1, 32'h10,  1'b0, 32'h0,  32'h80,      1'b0, 32'h0,   32'h84,      1'b1, 32'h10,  16'd5,  16'd3};
      vecs[8]  = '{1'b1, 32'h80,  1'b1, 32'h200, 1'b0, 32'h0,  32'h40,      1'b1, 32'h10,  32'h10,      1'b1, 32'h200, 16'd6,  16'd4};
      vecs[9]  = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,  32'h80,      1'b1, 32'h200, 32'h200,     1'b0, 32'h0,   16'd7,  16'd5};
      vecs[10] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,  32'h40,      1'b0, 32'h0,   32'h44,      1'b0, 32'h0,   16'd7,  16'd5};
      vecs[11] = '{1'b1, 32'h40,  1'b1, 32'h10,  1'b0, 32'h0,  32'hFFFFFFFC, 1'b0, 32'h0,  32'h0,       1'b1, 32'h10,  16'd7,  16'd5};
      vecs[12] = '{1'b1, 32'h40,  1'b1, 32'h20,  1'b1, 32'h10, 32'h40,      1'b1, 32'h10,  32'h10,      1'b1, 32'h20,  16'd8,  16'd6};
      vecs[13] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,  32'h40,      1'b1, 32'h20,  32'h20,      1'b0, 32'h0,   16'd9,  16'd7};
      vecs[14] = '{1'b1, 32'h104, 1'b0, 32'h300, 1'b0, 32'h0,  32'h200,     1'b0, 32'h0,   32'h204,     1'b0, 32'h0,   16'd9,  16'd7};
      vecs[15] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,  32'h104,     1'b0, 32'h300, 32'h108,     1'b0, 32'h0,   16'd10, 16'd7};
      vecs[16] = '{1'b1, 32'h104, 1'b1, 32'h300, 1'b0, 32'h0,  32'h104,     1'b0, 32'h300, 32'h108,     1'b1, 32'h300, 16'd10, 16'd7};
      vecs[17] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,  32'h104,     1'b1, 32'h300, 32'h300,     1'b0, 32'h0,   16'd11, 16'd8};

      // Reset state
      #2;
      chk("rst_pred_taken",   {31'd0, pred_taken}, 32'd0);
      chk("rst_pred_target",  pred_target,         32'd0);
      chk("rst_pred_pc_next", pred_pc_next,        32'h104);
      chk("rst_branch_cnt",   {16'd0, branch_count},     32'd0);
      chk("rst_mispred_cnt",  {16'd0, mispredict_count}, 32'd0);
      chk("rst_mispredict",   {31'd0, mispredict}, 32'd0);
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1;

      // Vector table: inputs applied just after an edge, outputs checked before the next
      foreach (vecs[i]) begin
         @(posedge CLK);
         #1;
         drive_ex(vecs[i].exv, vecs[i].expc, vecs[i].ext, vecs[i].extgt, vecs[i].expt, vecs[i].exptgt);
         if_pc = vecs[i].ifpc;
         #2;
         chk($sformatf("v%0d_pred_taken", i),   {31'd0, pred_taken}, {31'd0, vecs[i].e_pt});
         chk($sformatf("v%0d_pred_target", i),  pred_target,         vecs[i].e_ptgt);
         chk($sformatf("v%0d_pred_pc_next", i), pred_pc_next,        vecs[i].e_pcn);
         chk($sformatf("v%0d_mispredict", i),   {31'd0, mispredict}, {31'd0, vecs[i].e_mis});
         chk($sformatf("v%0d_redirect_pc", i),  redirect_pc,         vecs[i].e_red);
         chk($sformatf("v%0d_branch_cnt", i),   {16'd0, branch_count},     {16'd0, vecs[i].e_bc});
         chk($sformatf("v%0d_mispred_cnt", i),  {16'd0, mispredict_count}, {16'd0, vecs[i].e_mc});
      end

      // Asynchronous reset between edges after training
      @(posedge CLK);
      #1;
      drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      if_pc = 32'h40;
      #1;
      chk("pre_rst_pred_taken", {31'd0, pred_taken}, 32'd1);
      #1;
      RST = 1'b0;
      #1;
      chk("async_rst_pred_taken",   {31'd0, pred_taken}, 32'd0);
      chk("async_rst_pred_target",  pred_target,         32'd0);
      chk("async_rst_pred_pc_next", pred_pc_next,        32'h44);
      chk("async_rst_branch_cnt",   {16'd0, branch_count},     32'd0);
      chk("async_rst_mispred_cnt",  {16'd0, mispredict_count}, 32'd0);
      chk("async_rst_sat_branch_cnt", {29'd0, s_branch_count}, 32'd0);
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      chk("post_rst_pred_taken", {31'd0, pred_taken}, 32'd0);

      // Statistics saturation on the narrow instance (all-ones = 7)
      drive_ex(1'b1, 32'h40, 1'b1, 32'h10, 1'b0, 32'h0);
      repeat (7) @(posedge CLK);
      #1;
      chk("sat_branch_cnt_full",  {29'd0, s_branch_count},     32'd7);
      chk("sat_mispred_cnt_full", {29'd0, s_mispredict_count}, 32'd7);
      @(posedge CLK);
      #1;
      drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      chk("sat_branch_cnt_hold",  {29'd0, s_branch_count},     32'd7);
      chk("sat_mispred_cnt_hold", {29'd0, s_mispredict_count}, 32'd7);
      chk("wide_branch_cnt",      {16'd0, branch_count},       32'd8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor feeding the fetch stage's next-PC selection.
- Holds a direct-mapped table. Each entry has a valid bit, a tag, a target and a 2-bit saturating counter (a combined BHT and BTB).
- Looks up the current IF PC combinationally and produces the predicted next PC.
- Is trained by branch/jump resolution from EX, and flags mispredictions with the redirect PC used to flush IF/ID.

Parameters:
- ENTRIES, 16, number of table entries; power of two, at least 2.
- IDX_W, $clog2(ENTRIES), index width (derived; do not override).
- CNT_W, 16, width of the statistics counters.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- if_pc  input  32  PC of the instruction currently in IF.
- pred_taken  output  1  prediction for if_pc is taken.
- pred_target  output  32  stored target on a hit, else 0.
- pred_pc_next  output  32  pred_taken ? pred_target : if_pc+4.
- ex_valid  input  1  a branch/jump is resolved in EX this cycle.
- ex_pc  input  32  PC of the resolved branch.
- ex_taken  input  1  actual outcome.
- ex_target  input  32  actual target.
- ex_pred_taken  input  1  prediction carried down the pipeline with this branch.
- ex_pred_target  input  32  predicted target carried down the pipeline.
- mispredict  output  1  flush request.
- redirect_pc  output  32  correct PC after a mispredict.
- branch_count  output  CNT_W  number of resolved branches.
- mispredict_count  output  CNT_W  number of mispredictions.

Behaviour:
- Address split:
  - index = pc[IDX_W+1:2]
  - tag = pc[31:IDX_W+2]
  - pc[1:0] is ignored.
- Lookup is purely combinational from if_pc and the current table state.
  - hit = valid[idx] && tag[idx] == if_pc tag.
  - pred_taken = hit && cnt[idx][1].
  - pred_target = hit ? target[idx] : 0.
- Counter encoding:
  - 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
- Update happens on the rising CLK edge when ex_valid=1, at the entry selected by ex_pc's index.
  - EX hit, taken: cnt = min(cnt+1, 3); target = ex_target.
  - EX hit, not taken: cnt = max(cnt-1, 0); target unchanged.
  - EX miss (invalid entry or tag mismatch): allocate or replace the entry with valid=1, tag from ex_pc, target = ex_target, cnt = ex_taken ? 10 : 01.
  - ex_valid=0: table unchanged.
- Read-during-write: when a lookup and an update hit the same entry in one cycle, the lookup sees the pre-update contents. There is no bypass; the new value is visible the next cycle.
- mispredict (combinational) = ex_valid && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target)).
- redirect_pc = mispredict ? (ex_taken ? ex_target : ex_pc+4) : 0.
- Statistics counters, updated at the clock edge:
  - branch_count increments on each ex_valid.
  - mispredict_count increments on each mispredict.
  - Both saturate at all-ones; they never wrap.
- PC+4 arithmetic is 32-bit modulo: 0xFFFFFFFC+4 = 0x00000000.
- Reset (RST=0), asynchronous and taking effect immediately without a clock edge:
  - All valid bits cleared, all counters set to 01, tags and targets set to 0.
  - Statistics counters cleared.
  - Resulting outputs: pred_taken=0, pred_target=0, pred_pc_next=if_pc+4, mispredict=0 unless driven by ex_* inputs.
  - The bench holds ex_valid=0 during reset.
  - Updates are ignored while RST=0.
  - Reset asserted mid-update discards that update.

Test Plan:
1. Reset, if_pc=0x100 -> pred_taken=0, pred_target=0, pred_pc_next=0x104, both counts 0.
2. ex_valid=1, ex_pc=0x40, ex_taken=1, ex_target=0x10, ex_pred_taken=0 -> same cycle: mispredict=1, redirect_pc=0x10. Next cycle, if_pc=0x40 -> pred_taken=1, pred_pc_next=0x10, branch_count=1, mispredict_count=1.
3. Hysteresis at pc 0x40:
   - Two more taken updates -> cnt=11.
   - One not-taken -> cnt=10, still predicts taken.
   - Second not-taken -> cnt=01, pred_pc_next=0x44.
   - Not-taken resolution with ex_pred_taken=1 -> redirect_pc=0x44.
4. Aliasing with ENTRIES=16:
   - Allocate 0x40 (taken). Lookup 0x80 (same index 0, different tag) -> miss, pred_pc_next=0x84.
   - Update 0x80 taken to 0x200 -> 0x80 predicts 0x200, 0x40 now misses.
5. Read-during-write: same-cycle update and lookup of 0x40 after allocating taken to 0x10, with ex_target=0x20 -> lookup shows 0x10 that cycle, 0x20 the next.
6. Edge cases:
   - Assert RST low between clock edges after training -> pred_taken drops to 0 immediately and counts read 0.
   - Force branch_count to all-ones, then one more ex_valid -> stays all-ones.
   - if_pc=0xFFFFFFFC on a miss -> pred_pc_next=0.
